// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: XLEN, load/store width codes, memory FSM states
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'd0;  // LB / SB
  localparam logic [2:0] F3_H  = 3'd1;  // LH / SH
  localparam logic [2:0] F3_W  = 3'd2;  // LW / SW
  localparam logic [2:0] F3_BU = 3'd4;  // LBU
  localparam logic [2:0] F3_HU = 3'd5;  // LHU

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/data_memory_if.sv
// rtl/data_memory_if.sv - CPU request/response channel of the data memory
interface data_memory_if;
  import cpu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_fault;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

endinterface

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - byte-lane steering, load extension and alignment checks
module load_store_align
  import cpu_pkg::*;
(
  input  logic            write_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rword_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            misalign_o,
  output logic            illegal_o
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = rword_i[{offset_i, 3'b000} +: 8];
  assign lane_half = rword_i[{offset_i[1], 4'b0000} +: 16];

  // Store data is replicated across lanes; the byte enables pick the live ones.
  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = '0;
    rdata_o    = '0;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    case (funct3_i)
      F3_B: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{(XLEN-8){lane_byte[7]}}, lane_byte};
      end
      F3_H: begin
        misalign_o = offset_i[0];
        be_o       = 4'b0011 << offset_i;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{(XLEN-16){lane_half[15]}}, lane_half};
      end
      F3_W: begin
        misalign_o = |offset_i;
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rword_i;
      end
      F3_BU: begin
        illegal_o = write_i;
        rdata_o   = {{(XLEN-8){1'b0}}, lane_byte};
      end
      F3_HU: begin
        illegal_o  = write_i;
        misalign_o = offset_i[0];
        rdata_o    = {{(XLEN-16){1'b0}}, lane_half};
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - wait-stated word-organised data memory with byte/half/word access
module data_memory
  import cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input logic          clk,
  input logic          reset_n,
  data_memory_if.slave mem_if
);

  localparam int              AW         = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(4 * DEPTH_WORDS);

  mem_state_e      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            fault_q, fault_d;

  logic            in_idle, accept, enter_resp, mem_we;
  logic            cur_write;
  logic [2:0]      cur_funct3;
  logic [XLEN-1:0] cur_addr, cur_wdata;
  logic [AW-1:0]   word_idx;
  logic [XLEN-1:0] rword, wdata_al, rdata_ext;
  logic [3:0]      be;
  logic            misalign, illegal, fault;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  assign in_idle = (state_q == IDLE);
  assign accept  = mem_if.req_valid && in_idle;

  // With zero wait states the commit edge is the accept edge, so decode the live request.
  assign cur_write  = in_idle ? mem_if.req_write  : write_q;
  assign cur_funct3 = in_idle ? mem_if.req_funct3 : funct3_q;
  assign cur_addr   = in_idle ? mem_if.req_addr   : addr_q;
  assign cur_wdata  = in_idle ? mem_if.req_wdata  : wdata_q;

  assign word_idx = cur_addr[AW+1:2];
  assign rword    = mem[word_idx];
  assign fault    = misalign || illegal || (cur_addr >= ADDR_LIMIT);

  load_store_align u_align (
    .write_i    (cur_write),
    .funct3_i   (cur_funct3),
    .offset_i   (cur_addr[1:0]),
    .wdata_i    (cur_wdata),
    .rword_i    (rword),
    .be_o       (be),
    .wdata_o    (wdata_al),
    .rdata_o    (rdata_ext),
    .misalign_o (misalign),
    .illegal_o  (illegal)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'(WAIT_STATES - 1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (mem_if.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      fault_d = fault;
      rdata_d = (fault || cur_write) ? '0 : rdata_ext;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      if (accept) begin
        write_q  <= mem_if.req_write;
        funct3_q <= mem_if.req_funct3;
        addr_q   <= mem_if.req_addr;
        wdata_q  <= mem_if.req_wdata;
      end
    end
  end

  // The array is deliberately not reset; reset_n only blocks writes while held.
  assign mem_we = enter_resp && cur_write && !fault && reset_n;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wdata_al[8*b +: 8];
      end
    end
  end

  assign mem_if.req_ready = in_idle;
  assign mem_if.rsp_valid = (state_q == RESP);
  assign mem_if.rsp_rdata = rdata_q;
  assign mem_if.rsp_fault = fault_q;

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words stored; SHALL be a power of two >= 4.
REQ-002 Parameter WAIT_STATES, default 1: extra access cycles per request; range 0..15.
REQ-003 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU presents a request.
- req_ready  out  1  block accepts a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V load/store width code.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  CPU consumes the response.
- rsp_rdata  out  XLEN  load result, extended.
- rsp_fault  out  1  request was rejected.
REQ-004 There SHALL be one clock; reset SHALL be asynchronous and active-low, ports named clk and reset_n.

Function
REQ-005 FSM states SHALL be IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-006 Accept on req_valid&&req_ready: capture write, funct3, addr and wdata; go to WAIT if WAIT_STATES>0, else RESP.
REQ-007 WAIT SHALL count WAIT_STATES cycles, then go to RESP; rsp_valid SHALL rise exactly 1+WAIT_STATES cycles after the accept edge.
REQ-008 RESP SHALL hold rsp_valid=1 and rsp_rdata/rsp_fault stable until rsp_valid&&rsp_ready, then return to IDLE.
REQ-009 A new request SHALL be accepted no earlier than the cycle after the response handshake; no same-cycle turnaround.
REQ-010 Loads: funct3 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU; byte lane = addr[1:0]; LB/LH sign-extend and LBU/LHU zero-extend to XLEN.
REQ-011 Stores: funct3 0=SB, 1=SH, 2=SW; write only the addressed byte lanes with the low bits of wdata; other lanes of the word are unchanged.
REQ-012 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-013 Fault SHALL be raised for any of:
- halfword access with addr[0]=1
- word access with addr[1:0]!=0
- addr >= 4*DEPTH_WORDS
- illegal funct3 (loads 3,6,7; stores 3..7)
REQ-014 On fault: no memory write; rsp_rdata=0; rsp_fault=1.
REQ-015 Store responses SHALL return rsp_rdata=0 and rsp_fault=0 when legal.
REQ-016 A store SHALL commit to memory on the edge entering RESP, so a following load observes it.
REQ-017 req_* inputs SHALL be ignored outside IDLE; rsp_ready SHALL be ignored outside RESP.

Reset
REQ-018 Asserting reset_n=0 SHALL force state IDLE, wait counter 0, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_fault=0.
REQ-019 Reset during WAIT SHALL discard the request; an uncommitted store SHALL NOT modify memory.
REQ-020 Memory array contents SHALL NOT be reset; words keep their prior value across reset and are unknown at power-up.

Structure
REQ-021 Shared package cpu_pkg SHALL hold XLEN (32), the funct3 load/store encodings and the FSM state enum.
REQ-022 Sub-module load_store_align SHALL be purely combinational and produce the byte-enable, the shifted write data, the extended load data and the misalignment flag; the FSM and array stay in data_memory.

Verification
REQ-023 The bench SHALL cover these scenarios:
- WAIT_STATES=1: SW 0x8 data 0xDEADBEEF, then LW 0x8 -> rsp_rdata 0xDEADBEEF, rsp_fault 0; each response 2 cycles after its accept.
- After the word above: LB 0xB -> 0xFFFFFFDE; LBU 0xB -> 0x000000DE; LH 0xA -> 0xFFFFDEAD; LHU 0x8 -> 0x0000BEEF.
- SB 0x9 data 0x12 over 0xDEADBEEF, then LW 0x8 -> 0xDEAD12EF.
- LW 0x6, SH 0x3, funct3=3 load, and LW 0x400 (DEPTH 256) -> each rsp_fault=1, rsp_rdata 0, memory unchanged.
- rsp_ready held 0 for 5 cycles -> rsp_valid and data stable, req_ready 0; accept resumes the cycle after the handshake.
- reset_n pulsed low during WAIT of SW 0x10 data 0x1 (WAIT_STATES=3) -> rsp_valid 0 and FSM in IDLE; a later LW 0x10 returns the pre-store value.
